grain_prog_loader: RTL

GRAIN_PROG_LOADER -- requirements
Module: grain_prog_loader

---
 rtl/grain_prog_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/grain_prog_loader.sv
// Bitstream loader for the fabric configuration chain: resets the chain, then
// shifts each accepted byte out MSB first on prog_clk while capturing readback.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start, all outputs low
// ST_RESET | prog_rst held high for RST_CYCLES clk cycles
// ST_LOAD  | s_ready high, waiting for the next bitstream byte
// ST_SHIFT | 8 bits, each a low then a high prog_clk phase of CLK_DIV cycles
// ST_DONE  | one-cycle done strobe before returning to idle
module grain_prog_loader #(
  parameter int CLK_DIV    = 4,
  parameter int RST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       prog_clk,
  output logic       prog_rst,
  output logic       prog_en,
  output logic       prog_din,
  input  logic       prog_dout,
  output logic [7:0] rb_data,
  output logic       rb_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] RST_RELOAD = 8'(RST_CYCLES - 1);

  state_t     state;
  logic [7:0] tmr;
  logic [2:0] bit_idx;
  logic [6:0] tx_sr;
  logic [7:0] rb_sr;
  logic       last_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tmr       <= 8'd0;
      bit_idx   <= 3'd0;
      tx_sr     <= 7'd0;
      rb_sr     <= 8'd0;
      last_flag <= 1'b0;
      s_ready   <= 1'b0;
      prog_clk  <= 1'b0;
      prog_rst  <= 1'b0;
      prog_en   <= 1'b0;
      prog_din  <= 1'b0;
      rb_data   <= 8'd0;
      rb_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RESET;
            busy     <= 1'b1;
            prog_rst <= 1'b1;
            tmr      <= RST_RELOAD;
          end
        end

        ST_RESET: begin
          if (tmr == 8'd0) begin
            state    <= ST_LOAD;
            prog_rst <= 1'b0;
            s_ready  <= 1'b1;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end

        // The first bit goes out on the accept edge so prog_din is settled
        // for the whole low phase of bit 7.
        ST_LOAD: begin
          if (s_valid && s_ready) begin
            state     <= ST_SHIFT;
            s_ready   <= 1'b0;
            tx_sr     <= s_data[6:0];
            last_flag <= s_last;
            prog_din  <= s_data[7];
            prog_en   <= 1'b1;
            prog_clk  <= 1'b0;
            bit_idx   <= 3'd0;
            tmr       <= DIV_RELOAD;
          end
        end

        ST_SHIFT: begin
          if (tmr != 8'd0) begin
            tmr <= tmr - 8'd1;
          end else if (!prog_clk) begin
            // Readback is sampled on the same edge that raises prog_clk.
            prog_clk <= 1'b1;
            rb_sr    <= {rb_sr[6:0], prog_dout};
            tmr      <= DIV_RELOAD;
          end else if (bit_idx != 3'd7) begin
            prog_clk <= 1'b0;
            bit_idx  <= bit_idx + 3'd1;
            prog_din <= tx_sr[6];
            tx_sr    <= {tx_sr[5:0], 1'b0};
            tmr      <= DIV_RELOAD;
          end else begin
            prog_clk <= 1'b0;
            prog_en  <= 1'b0;
            prog_din <= 1'b0;
            rb_data  <= rb_sr;
            rb_valid <= 1'b1;
            if (last_flag) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state   <= ST_LOAD;
              s_ready <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state    <= ST_IDLE;
          s_ready  <= 1'b0;
          prog_clk <= 1'b0;
          prog_rst <= 1'b0;
          prog_en  <= 1'b0;
          prog_din <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
